// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty instruction sequencer: state encoding,
// default instruction width / halt word, and a saturating counter helper.
package bitty_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam logic [15:0] HALT_WORD_DEF = 16'h0000;

    // ST_STEPWAIT is only reachable when single-step support is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_MEMWAIT  = 3'd2,
        ST_EXEC     = 3'd3,
        ST_HALT     = 3'd4,
        ST_ERROR    = 3'd5,
        ST_STEPWAIT = 3'd6
    } seq_state_t;

    // Retired-instruction counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bitty_seq_wdog.sv
// Watchdog counter for the bitty sequencer: cleared when an instruction is
// loaded, counts while the core executes, flags the terminal count
// (LIMIT-1) and holds there.
module bitty_seq_wdog #(
    parameter int LIMIT = 15,
    parameter int CW    = (LIMIT < 2) ? 1 : $clog2(LIMIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CW-1:0] count;

    assign tc = (count == CW'(LIMIT - 1));

    // Clear has priority; counting stops at the terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/bitty_sequencer.sv
// Instruction sequencer for the bitty core. Owns the PC, fetches from a
// synchronous instruction memory (one-cycle read latency), holds run high
// while the core executes and advances on core_done. Stops on HALT_WORD or
// when the watchdog expires.
// Optional build macro: BITTY_SEQ_STEP_EN adds a step input and a STEPWAIT
// state so that each instruction after the first needs a step pulse.
module bitty_sequencer
    import bitty_pkg::*;
#(
    parameter int                 ADDR_W      = 8,
    parameter int                 INSTR_W     = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] HALT_WORD   = INSTR_W'(HALT_WORD_DEF),
    parameter int                 WDOG_CYCLES = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
`ifdef BITTY_SEQ_STEP_EN
    input  logic               step,
`endif
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               run,
    input  logic               core_done,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output logic               error,
    output logic [15:0]        retired
);

    seq_state_t state_q;
    seq_state_t state_d;

    logic run_d;
    logic rd_en_d;
    logic busy_d;
    logic halted_d;
    logic error_d;

    logic start_ok;
    logic retire;
    logic is_halt;
    logic wdog_tc;

    assign retire   = (state_q == ST_EXEC) && core_done;
    assign is_halt  = (mem_rdata == HALT_WORD);
    assign mem_addr = pc;

    bitty_seq_wdog #(
        .LIMIT (WDOG_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == ST_MEMWAIT),
        .enable (state_q == ST_EXEC),
        .tc     (wdog_tc)
    );

    // start is honoured only when the sequencer is parked.
    always_comb begin
        start_ok = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT, ST_ERROR: start_ok = start;
`ifdef BITTY_SEQ_STEP_EN
            ST_STEPWAIT:                start_ok = start;
`endif
            default:                    start_ok = 1'b0;
        endcase
    end

    // State register plus the registered copies of the status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            run       <= 1'b0;
            mem_rd_en <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run       <= run_d;
            mem_rd_en <= rd_en_d;
            busy      <= busy_d;
            halted    <= halted_d;
            error     <= error_d;
        end
    end

    // Next-state logic; core_done beats a coincident watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT, ST_ERROR: begin
                if (start_ok) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_MEMWAIT;
            ST_MEMWAIT: begin
                state_d = is_halt ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (core_done) begin
`ifdef BITTY_SEQ_STEP_EN
                    state_d = ST_STEPWAIT;
`else
                    state_d = ST_FETCH;
`endif
                end else if (wdog_tc) begin
                    state_d = ST_ERROR;
                end
            end
`ifdef BITTY_SEQ_STEP_EN
            ST_STEPWAIT: begin
                if (start_ok || step) state_d = ST_FETCH;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode of the next state, registered alongside state_q.
    always_comb begin
        run_d    = (state_d == ST_EXEC);
        rd_en_d  = (state_d == ST_FETCH);
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_MEMWAIT) ||
                   (state_d == ST_EXEC);
        halted_d = (state_d == ST_HALT);
        error_d  = (state_d == ST_ERROR);
    end

    // PC, retired count and instruction latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            retired <= '0;
            instr   <= '0;
        end else begin
            if (start_ok) begin
                pc      <= start_addr;
                retired <= '0;
            end else if (retire) begin
                pc      <= pc + ADDR_W'(1);
                retired <= sat_inc16(retired);
            end
            if ((state_q == ST_MEMWAIT) && !is_halt) begin
                instr <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bitty_sequencer.sv
// Directed self-checking bench for bitty_sequencer: behavioural instruction
// memory, a core model that pulses core_done a programmable number of
// cycles after run rises, and a queue of expected instructions checked at
// every run rising edge.
module tb_bitty_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
`ifdef BITTY_SEQ_STEP_EN
    logic        step;
`endif
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        run;
    logic        core_done;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        error;
    logic [15:0] retired;

    logic [15:0] mem [0:255];
    logic [15:0] exp_q[$];

    int tests = 0;
    int fails = 0;
    int done_delay = 3;
    int exec_cnt = 0;
    int windows = 0;
    int run_len_cur = 0;
    int last_run_len = 0;
    int rd_cnt = 0;
    logic run_q = 1'b0;

    bitty_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
`ifdef BITTY_SEQ_STEP_EN
        .step       (step),
`endif
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .run        (run),
        .core_done  (core_done),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .error      (error),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Core model: core_done on the done_delay-th cycle of run (0 = never).
    always @(negedge clk) begin
        if (run) begin
            exec_cnt++;
            core_done = (done_delay != 0) && (exec_cnt == done_delay);
        end else begin
            exec_cnt  = 0;
            core_done = 1'b0;
        end
    end

    // Monitor: run windows, their lengths, read strobes, scoreboard pops.
    always @(negedge clk) begin
        if (run) run_len_cur++;
        if (run && !run_q) begin
            windows++;
            check("run_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("instr_at_run", 32'(instr), 32'(exp_q.pop_front()));
        end
        if (!run && run_q) begin
            last_run_len = run_len_cur;
            run_len_cur  = 0;
        end
        run_q = run;
        if (mem_rd_en) rd_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] a);
        start_addr = a;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_stop(input int max);
        for (int i = 0; i < max; i++) begin
            if (halted || error) break;
            tick(1);
        end
        check("stop_reached", 32'(halted || error), 32'd1);
    endtask

    task automatic wait_retired(input logic [15:0] n, input int max);
        for (int i = 0; i < max; i++) begin
            if (retired == n) break;
            tick(1);
        end
        check("retired_reached", 32'(retired), 32'(n));
    endtask

    task automatic wait_run(input int max);
        for (int i = 0; i < max; i++) begin
            if (run) break;
            tick(1);
        end
        check("run_reached", 32'(run), 32'd1);
    endtask

    initial begin
        int w0;
        int rd0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b1;
        start = 1'b0;
        start_addr = 8'h00;
`ifdef BITTY_SEQ_STEP_EN
        step = 1'b0;
`endif
        tick(2);
        check("rst_run", 32'(run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        reset = 1'b0;
        tick(2);

        // Basic program: two instructions then halt.
        mem[0] = 16'h2A49; mem[1] = 16'h4C4C; mem[2] = 16'h0000;
        done_delay = 3;
        w0 = windows;
        exp_q.push_back(16'h2A49);
        exp_q.push_back(16'h4C4C);
        do_start(8'h00);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        wait_stop(100);
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_error", 32'(error), 32'd0);
        check("t1_pc", 32'(pc), 32'd2);
        check("t1_retired", 32'(retired), 32'd2);
        check("t1_instr_kept", 32'(instr), 32'h4C4C);
        check("t1_windows", 32'(windows - w0), 32'd2);
        check("t1_run_len", 32'(last_run_len), 32'd3);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // PC wrap from 8'hFF to 8'h00.
        mem[8'hFF] = 16'h1111; mem[0] = 16'h2222; mem[1] = 16'h0000;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        do_start(8'hFF);
        check("t2_retired_cleared", 32'(retired), 32'd0);
        wait_retired(16'd1, 50);
        check("t2_pc_wrap", 32'(pc), 32'h00);
        wait_stop(100);
        check("t2_halted", 32'(halted), 32'd1);
        check("t2_pc", 32'(pc), 32'h01);
        check("t2_retired", 32'(retired), 32'd2);

        // Watchdog expiry, then recovery with a fresh start.
        mem[8'h10] = 16'h3333; mem[8'h11] = 16'h0000;
        done_delay = 0;
        exp_q.push_back(16'h3333);
        do_start(8'h10);
        check("t3_halted_cleared", 32'(halted), 32'd0);
        wait_stop(100);
        check("t3_error", 32'(error), 32'd1);
        check("t3_not_halted", 32'(halted), 32'd0);
        check("t3_run_len", 32'(last_run_len), 32'd15);
        check("t3_run", 32'(run), 32'd0);
        check("t3_pc", 32'(pc), 32'h10);
        check("t3_retired", 32'(retired), 32'd0);
        done_delay = 3;
        exp_q.push_back(16'h3333);
        do_start(8'h10);
        check("t3_error_cleared", 32'(error), 32'd0);
        wait_stop(100);
        check("t3b_halted", 32'(halted), 32'd1);
        check("t3b_error", 32'(error), 32'd0);
        check("t3b_retired", 32'(retired), 32'd1);
        check("t3b_pc", 32'(pc), 32'h11);

        // core_done on the watchdog terminal cycle retires normally.
        mem[8'h20] = 16'h5555; mem[8'h21] = 16'h0000;
        done_delay = 15;
        exp_q.push_back(16'h5555);
        do_start(8'h20);
        wait_stop(100);
        check("t4_error", 32'(error), 32'd0);
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_retired", 32'(retired), 32'd1);
        check("t4_pc", 32'(pc), 32'h21);
        check("t4_run_len", 32'(last_run_len), 32'd15);

        // start ignored during EXEC; asynchronous reset mid-EXEC.
        mem[8'h30] = 16'h6666; mem[8'h31] = 16'h7777; mem[8'h32] = 16'h0000;
        done_delay = 3;
        exp_q.push_back(16'h6666);
        exp_q.push_back(16'h7777);
        do_start(8'h30);
        wait_retired(16'd1, 50);
        done_delay = 0;
        wait_run(20);
        tick(2);
        do_start(8'h40);
        tick(1);
        check("t5_pc_ignored_start", 32'(pc), 32'h31);
        check("t5_run_held", 32'(run), 32'd1);
        check("t5_retired_held", 32'(retired), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_run", 32'(run), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_pc", 32'(pc), 32'd0);
        check("t5_rst_retired", 32'(retired), 32'd0);
        check("t5_rst_error", 32'(error), 32'd0);
        tick(2);
        reset = 1'b0;
        exp_q.delete();
        tick(2);

`ifdef BITTY_SEQ_STEP_EN
        // Single-step: each retire parks until a step pulse.
        mem[8'h50] = 16'h1234; mem[8'h51] = 16'h5678; mem[8'h52] = 16'h0000;
        done_delay = 3;
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h5678);
        do_start(8'h50);
        wait_retired(16'd1, 50);
        rd0 = rd_cnt;
        tick(6);
        check("t6_no_fetch_1", 32'(rd_cnt - rd0), 32'd0);
        check("t6_busy_stepwait", 32'(busy), 32'd0);
        check("t6_not_halted", 32'(halted), 32'd0);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        wait_retired(16'd2, 50);
        rd0 = rd_cnt;
        tick(6);
        check("t6_no_fetch_2", 32'(rd_cnt - rd0), 32'd0);
        check("t6_still_not_halted", 32'(halted), 32'd0);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        wait_stop(50);
        check("t6_halted", 32'(halted), 32'd1);
        check("t6_pc", 32'(pc), 32'h52);
`else
        rd0 = rd_cnt;
        tick(4);
        check("idle_no_fetch", 32'(rd_cnt - rd0), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
